axi_stream_2_to_1_arbiter: RTL and testbench
============================================

# axi_stream_2_to_1_arbiter

Packet-granular AXI Stream arbiter that merges two input streams onto one output stream. Once a source is granted, it keeps the grant until its tlast beat is accepted. Arbitration between sources is round-robin. The block is the merge-side counterpart of the 1-to-2 tdest switch: it shares one downstream resource (a NIC port or DMA channel) between two requesters. The output passes through one register stage.

## Interface
Parameters:
- AXIS_BUS_WIDTH, 64, tdata width; tkeep is AXIS_BUS_WIDTH/8.
- AXIS_TID_WIDTH, 1, tid width.
- AXIS_TDEST_WIDTH, 1, tdest width.
- AXIS_TUSER_WIDTH, 1, tuser width.
- INITIAL_PRIORITY, 0, input that wins the first simultaneous request after reset.
- Zero widths are not supported.

Ports:
- aclk  in  1  clock. All interfaces are synchronous to aclk.
- aresetn  in  1  reset, synchronous, active-low.
- axis_in_0_{tdata,tkeep,tid,tdest,tuser,tlast,tvalid}  in  per params  input stream 0.
- axis_in_0_tready  out  1  ready for input stream 0.
- axis_in_1_*  same as axis_in_0_*  input stream 1.
- axis_out_{tdata,tkeep,tid,tdest,tuser,tlast,tvalid}  out  per params  merged output stream.
- axis_out_tready  in  1  downstream ready.
- grant  out  2  one-hot current owner; 00 when idle.

## Operation
- State machine states: IDLE, GRANT0, GRANT1.
- IDLE:
  - The winner is chosen combinationally from the tvalid inputs and the priority pointer `prio`.
  - If only one input is valid, that input wins.
  - If both are valid, input `prio` wins.
  - The winner's tready is asserted in the same cycle, so the first beat transfers with no arbitration bubble.
- On the first beat accepted in IDLE:
  - If that beat has tlast=0, go to GRANTx.
  - If tlast=1, stay in IDLE. A single-beat packet completes the arbitration round.
- GRANTx:
  - Only input x is passed through; the other input's tready is held at 0.
  - Leave GRANTx for IDLE when the tlast beat of input x is accepted.
- Priority pointer update:
  - On every accepted tlast beat from input x, `prio` <= ~x.
  - `prio` resets to INITIAL_PRIORITY.
- Per-beat acceptance: axis_in_x_tready = selected(x) && (!out_valid || axis_out_tready).
- Output register behaviour:
  - The register loads the selected input beat when it is empty or being drained.
  - All sideband fields pass unmodified.
  - While empty, the register holds all data fields at 0. This is a secure output: there is no stale data leakage.
- grant output:
  - Reads 01 in GRANT0 and 10 in GRANT1.
  - In IDLE it reads 00, even during a single-beat transfer.
- Input tvalid dropping mid-packet leaves the grant held. No timeout is applied.
- The non-granted input may assert and hold tvalid for any length of time. It is never acknowledged until the owner's packet completes.

## Timing
- Latency is 1 cycle from input handshake to axis_out_tvalid.
- Throughput is 1 beat per cycle, including back-to-back packets from either source.
- Reset values:
  - axis_out_tvalid = 0 and all axis_out data fields = 0.
  - Both input treadies = 0 during reset.
  - grant = 00, state = IDLE, prio = INITIAL_PRIORITY.
- Simultaneous events:
  - tlast acceptance and a new request on the other input in the same cycle: the next cycle is IDLE, and the new request wins with zero bubble.
  - The same input requesting again while the other input is waiting loses to the waiting input, because `prio` has flipped.
- Backpressure:
  - axis_out_tready low with the register full forces both input treadies low.
  - Register contents are held stable (AXI stability rule).
- Reset mid-packet:
  - State drops to IDLE and the register is cleared.
  - The partial packet is truncated downstream, with no tlast emitted. Upstream is responsible for flushing.

## Structure
- Shared package axis_pkg holds:
  - the state enum typedef (IDLE, GRANT0, GRANT1);
  - a beat struct typedef {tdata, tkeep, tid, tdest, tuser, tlast} parameterised by width localparams.
- Sub-module axis_reg_slice: a single-stage forward register slice with valid/ready. It is instantiated once for the output and is reusable by the 1-to-2 switch.
- Arbiter FSM and mux are implemented in the top module.

## Test plan
- Input 0 sends a 4-beat packet (tdata 0x10..0x13) while input 1 is idle:
  - output shows the 4 beats starting 1 cycle after the first handshake;
  - grant = 01 from beat 2 through beat 4;
  - input 1 tready stays 0 throughout.
- Both inputs assert tvalid with 3-beat packets simultaneously after reset, INITIAL_PRIORITY=0:
  - output order is packet 0 then packet 1, with no idle cycle between them;
  - a repeat pair of packets from both inputs then yields the order 1, 0.
- Input 1 sends continuous single-beat packets while input 0 holds a request:
  - grants alternate 1, 0, 1, 0;
  - grant stays 00 throughout;
  - output is continuous.
- axis_out_tready toggles 1,0,0,1 during a 5-beat packet:
  - no beat is lost or duplicated;
  - output fields stay stable while tready=0;
  - input tready follows the backpressure.
- Input 0 drops tvalid for 3 cycles mid-packet while input 1 is valid:
  - input 1 receives no tready until input 0's tlast is accepted;
  - axis_out_tvalid=0 and data=0 during the gap.
- aresetn asserted on beat 2 of a 4-beat packet:
  - the next cycle shows axis_out_tvalid=0, data=0, grant=00;
  - the next request on input 1 wins per INITIAL_PRIORITY rules.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI Stream types: arbiter state encoding and the default-width beat layout.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  localparam int AXIS_BUS_WIDTH_DEF   = 64;
  localparam int AXIS_TID_WIDTH_DEF   = 1;
  localparam int AXIS_TDEST_WIDTH_DEF = 1;
  localparam int AXIS_TUSER_WIDTH_DEF = 1;

  // Field order matches the flat beat vector carried through axis_reg_slice.
  typedef struct packed {
    logic [AXIS_BUS_WIDTH_DEF-1:0]   tdata;
    logic [AXIS_BUS_WIDTH_DEF/8-1:0] tkeep;
    logic [AXIS_TID_WIDTH_DEF-1:0]   tid;
    logic [AXIS_TDEST_WIDTH_DEF-1:0] tdest;
    logic [AXIS_TUSER_WIDTH_DEF-1:0] tuser;
    logic                            tlast;
  } axis_beat_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage forward register slice; payload is forced to zero whenever the stage is empty.
module axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         s_valid_i,
  input  logic [W-1:0] s_data_i,
  output logic         s_ready_o,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output logic [W-1:0] m_data_o
);

  logic         vld_q;
  logic [W-1:0] data_q;

  assign s_ready_o = !vld_q || m_ready_i;
  assign m_valid_o = vld_q;
  assign m_data_o  = data_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (s_ready_o) begin
      vld_q  <= s_valid_i;
      data_q <= s_valid_i ? s_data_i : '0;
    end
  end

endmodule

// File: rtl/axi_stream_2_to_1_arbiter.sv
// Packet-granular round-robin merge of two AXI streams into one registered output stream.
module axi_stream_2_to_1_arbiter
  import axis_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH   = 64,
  parameter int AXIS_TID_WIDTH   = 1,
  parameter int AXIS_TDEST_WIDTH = 1,
  parameter int AXIS_TUSER_WIDTH = 1,
  parameter int INITIAL_PRIORITY = 0
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_0_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_0_tkeep,
  input  logic [AXIS_TID_WIDTH-1:0]     axis_in_0_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0]   axis_in_0_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0]   axis_in_0_tuser,
  input  logic                          axis_in_0_tlast,
  input  logic                          axis_in_0_tvalid,
  output logic                          axis_in_0_tready,
  input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_1_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_1_tkeep,
  input  logic [AXIS_TID_WIDTH-1:0]     axis_in_1_tid,
  input  logic [AXIS_TDEST_WIDTH-1:0]   axis_in_1_tdest,
  input  logic [AXIS_TUSER_WIDTH-1:0]   axis_in_1_tuser,
  input  logic                          axis_in_1_tlast,
  input  logic                          axis_in_1_tvalid,
  output logic                          axis_in_1_tready,
  output logic [AXIS_BUS_WIDTH-1:0]     axis_out_tdata,
  output logic [AXIS_BUS_WIDTH/8-1:0]   axis_out_tkeep,
  output logic [AXIS_TID_WIDTH-1:0]     axis_out_tid,
  output logic [AXIS_TDEST_WIDTH-1:0]   axis_out_tdest,
  output logic [AXIS_TUSER_WIDTH-1:0]   axis_out_tuser,
  output logic                          axis_out_tlast,
  output logic                          axis_out_tvalid,
  input  logic                          axis_out_tready,
  output logic [1:0]                    grant
);

  typedef struct packed {
    logic [AXIS_BUS_WIDTH-1:0]   tdata;
    logic [AXIS_BUS_WIDTH/8-1:0] tkeep;
    logic [AXIS_TID_WIDTH-1:0]   tid;
    logic [AXIS_TDEST_WIDTH-1:0] tdest;
    logic [AXIS_TUSER_WIDTH-1:0] tuser;
    logic                        tlast;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  beat_t [1:0] in_beat;
  logic  [1:0] in_vld, sel, in_rdy, acc;
  beat_t       s_beat, m_beat;
  logic        s_valid, slot_rdy;

  arb_state_e  state_q;
  logic        prio_q;
  logic [1:0]  grant_q;

  assign in_beat[0] = {axis_in_0_tdata, axis_in_0_tkeep, axis_in_0_tid,
                       axis_in_0_tdest, axis_in_0_tuser, axis_in_0_tlast};
  assign in_beat[1] = {axis_in_1_tdata, axis_in_1_tkeep, axis_in_1_tid,
                       axis_in_1_tdest, axis_in_1_tuser, axis_in_1_tlast};
  assign in_vld     = {axis_in_1_tvalid, axis_in_0_tvalid};

  // In IDLE the winner is picked combinationally so the first beat moves with no bubble.
  always_comb begin
    sel = 2'b00;
    case (state_q)
      IDLE: begin
        if (in_vld[0] && (!in_vld[1] || !prio_q)) sel = 2'b01;
        else if (in_vld[1])                       sel = 2'b10;
      end
      GRANT0:  sel = 2'b01;
      GRANT1:  sel = 2'b10;
      default: sel = 2'b00;
    endcase
  end

  assign in_rdy  = sel & {2{slot_rdy & aresetn}};
  assign acc     = in_rdy & in_vld;
  assign s_valid = |(sel & in_vld);
  assign s_beat  = sel[1] ? in_beat[1] : in_beat[0];

  assign axis_in_0_tready = in_rdy[0];
  assign axis_in_1_tready = in_rdy[1];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      prio_q  <= 1'(INITIAL_PRIORITY);
    end else begin
      case (state_q)
        IDLE: begin
          if (acc[0] && !in_beat[0].tlast) begin
            state_q <= GRANT0;
            grant_q <= 2'b01;
          end else if (acc[1] && !in_beat[1].tlast) begin
            state_q <= GRANT1;
            grant_q <= 2'b10;
          end
        end
        GRANT0: if (acc[0] && in_beat[0].tlast) begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
        GRANT1: if (acc[1] && in_beat[1].tlast) begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
        end
      endcase
      if (acc[0] && in_beat[0].tlast)      prio_q <= 1'b1;
      else if (acc[1] && in_beat[1].tlast) prio_q <= 1'b0;
    end
  end

  axis_reg_slice #(.W(BEAT_W)) u_out_slice (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_valid_i (s_valid),
    .s_data_i  (s_beat),
    .s_ready_o (slot_rdy),
    .m_valid_o (axis_out_tvalid),
    .m_ready_i (axis_out_tready),
    .m_data_o  (m_beat)
  );

  assign axis_out_tdata  = m_beat.tdata;
  assign axis_out_tkeep  = m_beat.tkeep;
  assign axis_out_tid    = m_beat.tid;
  assign axis_out_tdest  = m_beat.tdest;
  assign axis_out_tuser  = m_beat.tuser;
  assign axis_out_tlast  = m_beat.tlast;
  assign grant           = grant_q;

endmodule

// File: tb/tb_axi_stream_2_to_1_arbiter.sv
// Randomized and directed bench for the 2-to-1 packet arbiter against a transaction-level model.
module tb_axi_stream_2_to_1_arbiter;

  typedef struct packed {
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tid;
    logic        tdest;
    logic        tuser;
    logic        tlast;
  } beat_t;

  localparam int INIT_PRIO = 0;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] axis_in_0_tdata = '0, axis_in_1_tdata = '0, axis_out_tdata;
  logic [7:0]  axis_in_0_tkeep = '0, axis_in_1_tkeep = '0, axis_out_tkeep;
  logic        axis_in_0_tid = 0, axis_in_0_tdest = 0, axis_in_0_tuser = 0, axis_in_0_tlast = 0;
  logic        axis_in_1_tid = 0, axis_in_1_tdest = 0, axis_in_1_tuser = 0, axis_in_1_tlast = 0;
  logic        axis_in_0_tvalid = 0, axis_in_1_tvalid = 0, axis_in_0_tready, axis_in_1_tready;
  logic        axis_out_tid, axis_out_tdest, axis_out_tuser, axis_out_tlast, axis_out_tvalid;
  logic        axis_out_tready = 1'b0;
  logic [1:0]  grant;

  always #5 aclk = ~aclk;

  axi_stream_2_to_1_arbiter #(
    .AXIS_BUS_WIDTH(64), .AXIS_TID_WIDTH(1), .AXIS_TDEST_WIDTH(1),
    .AXIS_TUSER_WIDTH(1), .INITIAL_PRIORITY(INIT_PRIO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in_0_tdata(axis_in_0_tdata), .axis_in_0_tkeep(axis_in_0_tkeep),
    .axis_in_0_tid(axis_in_0_tid), .axis_in_0_tdest(axis_in_0_tdest),
    .axis_in_0_tuser(axis_in_0_tuser), .axis_in_0_tlast(axis_in_0_tlast),
    .axis_in_0_tvalid(axis_in_0_tvalid), .axis_in_0_tready(axis_in_0_tready),
    .axis_in_1_tdata(axis_in_1_tdata), .axis_in_1_tkeep(axis_in_1_tkeep),
    .axis_in_1_tid(axis_in_1_tid), .axis_in_1_tdest(axis_in_1_tdest),
    .axis_in_1_tuser(axis_in_1_tuser), .axis_in_1_tlast(axis_in_1_tlast),
    .axis_in_1_tvalid(axis_in_1_tvalid), .axis_in_1_tready(axis_in_1_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tkeep(axis_out_tkeep),
    .axis_out_tid(axis_out_tid), .axis_out_tdest(axis_out_tdest),
    .axis_out_tuser(axis_out_tuser), .axis_out_tlast(axis_out_tlast),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .grant(grant)
  );

  int    n_tests = 0, n_fail = 0;
  int    owner = -1;          // packet owner in the reference model, -1 when unowned
  int    prio = INIT_PRIO;
  beat_t oq[$];               // beats held in the output stage
  beat_t seen[$];             // beats delivered downstream
  beat_t q0[$], q1[$];
  logic  mid0 = 0, mid1 = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic beat_t mk(int src, int base, int idx, logic last);
    beat_t b;
    b.tdata = {32'(src), 32'(base + idx)};
    b.tkeep = 8'(idx + 1);
    b.tid   = 1'(src);
    b.tdest = 1'(base >> 4);
    b.tuser = 1'(idx);
    b.tlast = last;
    return b;
  endfunction

  task automatic add_pkt(int src, int base, int len);
    for (int i = 0; i < len; i++) begin
      if (src == 0) q0.push_back(mk(0, base, i, i == len - 1));
      else          q1.push_back(mk(1, base, i, i == len - 1));
    end
  endtask

  // One clock: drive at negedge, check against the model, then advance the model past posedge.
  task automatic step(input logic v0, input beat_t b0, input logic v1, input beat_t b1,
                      input logic otr, input logic rst, output logic a0, output logic a1);
    int w;
    logic slot, r0, r1;
    beat_t cur;
    @(negedge aclk);
    aresetn = !rst;
    axis_in_0_tvalid = v0;
    {axis_in_0_tdata, axis_in_0_tkeep, axis_in_0_tid, axis_in_0_tdest, axis_in_0_tuser, axis_in_0_tlast} = b0;
    axis_in_1_tvalid = v1;
    {axis_in_1_tdata, axis_in_1_tkeep, axis_in_1_tid, axis_in_1_tdest, axis_in_1_tuser, axis_in_1_tlast} = b1;
    axis_out_tready = otr;
    #1;
    slot = (oq.size() == 0) || otr;
    w = owner;
    if (owner == -1) begin
      if (v0 && v1) w = prio;
      else if (v0)  w = 0;
      else if (v1)  w = 1;
    end
    r0 = !rst && slot && (w == 0);
    r1 = !rst && slot && (w == 1);
    cur = (oq.size() != 0) ? oq[0] : beat_t'('0);
    chk("in0_tready", axis_in_0_tready, r0);
    chk("in1_tready", axis_in_1_tready, r1);
    chk("out_tvalid", axis_out_tvalid, oq.size() != 0);
    chk("out_beat", {axis_out_tdata, axis_out_tkeep, axis_out_tid, axis_out_tdest,
                     axis_out_tuser, axis_out_tlast}, cur);
    chk("grant", grant, (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00);
    a0 = r0 && v0;
    a1 = r1 && v1;
    @(posedge aclk);
    if (rst) begin
      owner = -1;
      prio  = INIT_PRIO;
      oq.delete();
    end else begin
      if (oq.size() != 0 && otr) seen.push_back(oq.pop_front());
      if (a0 || a1) begin
        cur = a0 ? b0 : b1;
        w   = a0 ? 0 : 1;
        oq.push_back(cur);
        if (cur.tlast) begin owner = -1; prio = 1 - w; end
        else owner = w;
      end
    end
  endtask

  task automatic do_reset();
    logic a0, a1;
    repeat (2) step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, a0, a1);
    q0.delete(); q1.delete(); seen.delete();
    mid0 = 0; mid1 = 0;
  endtask

  // Feeds the source queues; ptr<0 selects the fixed 1,0,0,1 ready pattern.
  task automatic run(int ncyc, int pv, int ptr, int rst_at);
    logic p0, p1, a0, a1, otr;
    beat_t b;
    logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    p0 = 0; p1 = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (!p0 && q0.size() != 0 && $urandom_range(99) < pv) p0 = 1;
      if (!p1 && q1.size() != 0 && $urandom_range(99) < pv) p1 = 1;
      if (c == rst_at) begin
        step(p0, p0 ? q0[0] : beat_t'('0), p1, p1 ? q1[0] : beat_t'('0), 1'b1, 1'b1, a0, a1);
        if (mid0) while (q0.size() != 0) begin b = q0.pop_front(); if (b.tlast) break; end
        if (mid1) while (q1.size() != 0) begin b = q1.pop_front(); if (b.tlast) break; end
        mid0 = 0; mid1 = 0; p0 = 0; p1 = 0;
        continue;
      end
      otr = (ptr < 0) ? pat[c % 4] : ($urandom_range(99) < ptr);
      step(p0, p0 ? q0[0] : beat_t'('0), p1, p1 ? q1[0] : beat_t'('0), otr, 1'b0, a0, a1);
      if (a0) begin b = q0.pop_front(); mid0 = !b.tlast; p0 = 0; end
      if (a1) begin b = q1.pop_front(); mid1 = !b.tlast; p1 = 0; end
      if (q0.size() == 0 && q1.size() == 0 && oq.size() == 0 && !p0 && !p1) break;
    end
    chk("run_drained", q0.size() + q1.size() + oq.size(), 0);
  endtask

  task automatic chk_order(input string tag, input int exp_src[$], input int exp_lo[$]);
    chk({tag, "_count"}, seen.size(), exp_src.size());
    for (int i = 0; i < exp_src.size() && i < seen.size(); i++) begin
      chk({tag, "_src"}, seen[i].tdata[63:32], exp_src[i]);
      chk({tag, "_data"}, seen[i].tdata[31:0], exp_lo[i]);
    end
  endtask

  initial begin
    int es[$], el[$];
    logic a0, a1;
    beat_t p[4], c1;
    repeat (3) @(posedge aclk);
    do_reset();

    // 4-beat packet on input 0 alone
    add_pkt(0, 'h10, 4);
    run(30, 100, 100, -1);
    es = '{0, 0, 0, 0}; el = '{'h10, 'h11, 'h12, 'h13};
    chk_order("single_src", es, el);

    // simultaneous 3-beat packets, then a second pair
    do_reset();
    add_pkt(0, 'h100, 3); add_pkt(0, 'h110, 3);
    add_pkt(1, 'h200, 3); add_pkt(1, 'h210, 3);
    run(60, 100, 100, -1);
    es = '{0,0,0, 1,1,1, 0,0,0, 1,1,1};
    el = '{'h100,'h101,'h102, 'h200,'h201,'h202, 'h110,'h111,'h112, 'h210,'h211,'h212};
    chk_order("rr_pairs", es, el);

    // single-beat packets from both sides alternate
    do_reset();
    for (int i = 0; i < 4; i++) add_pkt(1, 'h300 + 16 * i, 1);
    for (int i = 0; i < 3; i++) add_pkt(0, 'h400 + 16 * i, 1);
    run(40, 100, 100, -1);
    es = '{0, 1, 0, 1, 0, 1, 1};
    el = '{'h400, 'h300, 'h410, 'h310, 'h420, 'h320, 'h330};
    chk_order("single_beat", es, el);

    // 5-beat packet under 1,0,0,1 backpressure
    do_reset();
    add_pkt(0, 'h500, 5);
    run(60, 100, -1, -1);
    es = '{0, 0, 0, 0, 0}; el = '{'h500, 'h501, 'h502, 'h503, 'h504};
    chk_order("backpressure", es, el);

    // input 0 goes quiet mid-packet while input 1 waits
    do_reset();
    for (int i = 0; i < 4; i++) p[i] = mk(0, 'h600, i, i == 3);
    c1 = mk(1, 'h700, 0, 1'b1);
    step(1, p[0], 1, c1, 1, 0, a0, a1);
    step(1, p[1], 1, c1, 1, 0, a0, a1);
    repeat (3) step(0, '0, 1, c1, 1, 0, a0, a1);
    step(1, p[2], 1, c1, 1, 0, a0, a1);
    step(1, p[3], 1, c1, 1, 0, a0, a1);
    chk("gap_hold_in1", a1, 1'b0);
    step(0, '0, 1, c1, 1, 0, a0, a1);
    chk("gap_in1_after", a1, 1'b1);
    repeat (3) step(0, '0, 0, '0, 1, 0, a0, a1);
    es = '{0, 0, 0, 0, 1}; el = '{'h600, 'h601, 'h602, 'h603, 'h700};
    chk_order("valid_gap", es, el);

    // reset on beat 2 of a 4-beat packet, then input 1 takes over
    do_reset();
    step(1, p[0], 0, '0, 1, 0, a0, a1);
    step(1, p[1], 0, '0, 1, 0, a0, a1);
    step(1, p[2], 0, '0, 1, 1, a0, a1);
    step(0, '0, 1, c1, 1, 0, a0, a1);
    chk("post_reset_in1", a1, 1'b1);
    repeat (3) step(0, '0, 0, '0, 1, 0, a0, a1);

    // randomized traffic with a reset in the middle, then without
    do_reset();
    for (int k = 0; k < 40; k++) add_pkt($urandom_range(1), k * 16, $urandom_range(1, 6));
    run(3000, 60, 70, 120);
    for (int k = 0; k < 40; k++) add_pkt($urandom_range(1), 'h1000 + k * 16, $urandom_range(1, 6));
    run(3000, 75, 60, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
